if_id_register: RTL and testbench

Fetch-side sequential block: the program-counter register that feeds the fetch stage, plus the IF/ID pipeline register that captures its outputs for decode. It consumes `pc_next`, `pc_4` and `inst_in` from the fetch stage and returns `pc` to it. It implements the hazard hooks for the forwarding / predict-not-taken pipeline:
- **stall** (load-use) freezes fetch.
- **flush** (taken branch/jump resolved in ID) squashes the wrong-path instruction.

It also keeps saturating stall/flush event counters for debug.

---
 rtl/if_id_register.sv | 56 +++++
 tb/tb_if_id_register.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_id_register.sv
// if_id_register: PC register plus IF/ID pipeline register with stall/flush hooks and saturating debug counters
module if_id_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_next,
    input  logic [31:0]      pc_4,
    input  logic [31:0]      inst_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [31:0]      pc,
    output logic [31:0]      id_pc_4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_inst  <= NOP_INST;
            id_pc_4  <= '0;
            id_valid <= 1'b0;
        end else if (flush) begin
            pc       <= pc_next;
            id_inst  <= NOP_INST;
            id_pc_4  <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            pc       <= pc_next;
            id_inst  <= inst_in;
            id_pc_4  <= pc_4;
            id_valid <= 1'b1;
        end
    end

    // a flush masks a simultaneous stall, so only true freeze cycles are counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && !(&flush_count))
                flush_count <= flush_count + CNT_W'(1);
            if (stall && !flush && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_if_id_register.sv
// tb_if_id_register: randomized scoreboard bench for the PC / IF/ID register
module tb_if_id_register;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc_next = '0, pc_4 = '0, inst_in = '0;
    logic          stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
    logic [31:0]   pc, id_pc_4, id_inst;
    logic          id_valid;
    logic [CW-1:0] stall_count, flush_count;

    if_id_register #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_4(pc_4), .inst_in(inst_in),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .pc(pc), .id_pc_4(id_pc_4),
        .id_inst(id_inst), .id_valid(id_valid), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, pc4, inst;
        logic        valid;
        int          sc, fc;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;

    logic [31:0] m_pc = '0, m_pc4 = '0, m_inst = '0;
    logic        m_valid = 1'b0;
    int          m_sc = 0, m_fc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("pc", pc, e.pc);
        chk("id_pc_4", id_pc_4, e.pc4);
        chk("id_inst", id_inst, e.inst);
        chk("id_valid", 32'(id_valid), 32'(e.valid));
        chk("stall_count", 32'(stall_count), 32'(e.sc));
        chk("flush_count", 32'(flush_count), 32'(e.fc));
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc; e.pc4 = m_pc4; e.inst = m_inst; e.valid = m_valid; e.sc = m_sc; e.fc = m_fc;
        return e;
    endfunction

    function automatic void model_reset();
        m_pc = '0; m_pc4 = '0; m_inst = '0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    endfunction

    // one clock: drive at negedge, update reference at posedge, queue expectation
    task automatic cycle(input logic s, input logic f, input logic c,
                         input logic [31:0] nxt, input logic [31:0] ins);
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        stall = s; flush = f; cnt_clr = c; pc_next = nxt; pc_4 = p4; inst_in = ins;
        @(posedge clk);
        if (f) begin
            m_pc = nxt; m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (!s) begin
            m_pc = nxt; m_inst = ins; m_pc4 = p4; m_valid = 1'b1;
        end
        if (c) begin
            m_sc = 0; m_fc = 0;
        end else begin
            m_fc = (m_fc + int'(f) > SAT) ? SAT : m_fc + int'(f);
            m_sc = (m_sc + int'(s && !f) > SAT) ? SAT : m_sc + int'(s && !f);
        end
        q.push_back(snap());
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) chk_all(q.pop_front());
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk_all(snap());
        rst_n = 1'b1;
        // sequential fetch, stall at pc=8, then flush to 0x40
        cycle(0, 0, 0, m_pc + 4, 32'h2001_0005);
        cycle(0, 0, 0, m_pc + 4, 32'h2001_0005);
        cycle(1, 0, 0, m_pc + 4, 32'h1111_1111);
        cycle(0, 0, 0, m_pc + 4, 32'h2002_0006);
        cycle(0, 1, 0, 32'h40, 32'h2222_2222);
        cycle(0, 0, 0, m_pc + 4, 32'h2003_0007);
        cycle(1, 1, 0, 32'h80, 32'h3333_3333);
        cycle(0, 0, 0, 32'hFFFF_FFFC, 32'h4444_4444);
        cycle(0, 0, 0, m_pc + 4, 32'h5555_5555);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, m_pc + 4, $urandom);
        cycle(1, 0, 1, m_pc + 4, $urandom);
        for (int i = 0; i < 18; i++) cycle(0, 1, 0, $urandom & 32'hFFFF_FFFC, $urandom);
        cycle(0, 0, 0, m_pc + 4, $urandom);
        for (int i = 0; i < 400; i++) begin
            logic s, f, c;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 40) == 0);
            cycle(s, f, c, f ? ($urandom & 32'hFFFF_FFFC) : m_pc + 4, $urandom);
        end
        // asynchronous reset while stalled, between edges
        cycle(1, 0, 0, m_pc + 4, $urandom);
        cycle(1, 0, 0, m_pc + 4, $urandom);
        stall = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(snap());
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, m_pc + 4, 32'h2001_0005);
        cycle(0, 0, 0, m_pc + 4, 32'h2004_0008);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
